// File: rtl/mapper_mem_req.sv
// mapper_mem_req: turns one mapper-selected CPU access into a single req/ack transaction on the memory port.
// Latency: cpu_wait is asserted combinationally in the start cycle N. mem_req rises at N+1. Read data and
//          cpu_data_valid appear the cycle after mem_ack, which is also the first cycle with cpu_wait low.
// Backpressure: the CPU is stalled through cpu_wait until mem_ack arrives. mem_req is held as a level until then.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   cpu_mreq/cpu_rd/cpu_wr   CPU memory strobes (level)
//   map_ram_cs/map_addr/map_rnw/map_data
//                            per-cycle mapper output (map_addr all-ones = unmapped)
//   cpu_wait/cpu_data/cpu_data_valid
//                            CPU stall and read-return path
//   mem_req/mem_addr/mem_we/mem_din/mem_ack/mem_dout
//                            memory req/ack port. mem_ack is a one-cycle pulse that carries the read data.
//   err                      sticky timeout flag
// Optional feature: define MAPPER_MEM_TIMEOUT_EN to abort a request that sees no ack within TIMEOUT
// BUSY cycles. When the macro is undefined, err is tied low.
module mapper_mem_req #(
   parameter int ADDR_W  = 27,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_mreq,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic              map_ram_cs,
   input  logic [ADDR_W-1:0] map_addr,
   input  logic              map_rnw,
   input  logic [DATA_W-1:0] map_data,
   output logic              cpu_wait,
   output logic [DATA_W-1:0] cpu_data,
   output logic              cpu_data_valid,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] cdata_q, cdata_d;
   logic              valid_q, valid_d;

   logic start, write, dropped, issue;

   // Start is gated by reset, so a CPU still holding its strobes during reset
   // neither stalls nor launches a request.
   assign start   = (state_q == IDLE) & cpu_mreq & map_ram_cs & (cpu_rd | cpu_wr)
                    & (map_addr != {ADDR_W{1'b1}}) & ~reset;
   // A write takes priority over a simultaneous read. A write into a read-only
   // target is swallowed: it issues no memory request and causes no stall.
   assign write   = cpu_wr & ~map_rnw;
   assign dropped = start & cpu_wr & map_rnw;
   assign issue   = start & ~dropped;

`ifdef MAPPER_MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      din_d   = din_q;
      cdata_d = cdata_q;
      valid_d = valid_q;
`ifdef MAPPER_MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (dropped) begin
               valid_d = 1'b0;
               state_d = HOLD;
            end else if (issue) begin
               addr_d  = map_addr;
               we_d    = write;
               din_d   = map_data;
               valid_d = 1'b0;
               state_d = BUSY;
`ifdef MAPPER_MEM_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         BUSY: begin
            // An ack that lands in the same cycle as the timeout wins.
            if (mem_ack) begin
               if (!we_q) begin
                  cdata_d = mem_dout;
                  valid_d = 1'b1;
               end
               state_d = HOLD;
            end
`ifdef MAPPER_MEM_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TO_LIM) begin
                  cdata_d = {DATA_W{1'b1}};
                  valid_d = 1'b1;
                  err_d   = 1'b1;
                  state_d = HOLD;
               end
            end
`endif
         end
         HOLD: begin
            // Wait here until the CPU ends the access, so one access makes one transaction.
            if (!cpu_mreq) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= {ADDR_W{1'b1}};
         we_q    <= 1'b0;
         din_q   <= '0;
         cdata_q <= {DATA_W{1'b1}};
         valid_q <= 1'b0;
`ifdef MAPPER_MEM_TIMEOUT_EN
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         din_q   <= din_d;
         cdata_q <= cdata_d;
         valid_q <= valid_d;
`ifdef MAPPER_MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign mem_req        = (state_q == BUSY);
   assign cpu_wait       = issue | (state_q == BUSY);
   assign mem_addr       = addr_q;
   assign mem_we         = we_q;
   assign mem_din        = din_q;
   assign cpu_data       = cdata_q;
   assign cpu_data_valid = valid_q;
`ifdef MAPPER_MEM_TIMEOUT_EN
   assign err            = err_q;
`else
   assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mapper_mem_req.sv
module tb_mapper_mem_req;

   localparam logic [26:0] NA = 27'h7FFFFFF;
   localparam logic [26:0] AA = 27'h0004000;
   localparam logic [26:0] AB = 27'h0012345;

   logic        clk = 1'b0;
   logic        reset, cpu_mreq, cpu_rd, cpu_wr, map_ram_cs, map_rnw, mem_ack;
   logic [26:0] map_addr, mem_addr;
   logic [7:0]  map_data, mem_dout, cpu_data, mem_din;
   logic        cpu_wait, cpu_data_valid, mem_req, mem_we, err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mapper_mem_req #(.ADDR_W(27), .DATA_W(8), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .map_ram_cs(map_ram_cs), .map_addr(map_addr), .map_rnw(map_rnw), .map_data(map_data),
      .cpu_wait(cpu_wait), .cpu_data(cpu_data), .cpu_data_valid(cpu_data_valid),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
      .mem_ack(mem_ack), .mem_dout(mem_dout), .err(err)
   );

   typedef struct {
      logic        rst, mreq, rd, wr, cs, rnw;
      logic [26:0] addr;
      logic [7:0]  data;
      logic        ack;
      logic [7:0]  dout;
      logic        e_wait, e_req, e_we, e_valid;
      logic [7:0]  e_cdata;
      logic [26:0] e_maddr;
      logic [7:0]  e_mdin;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, mreq, rd, wr, cs, rnw, input logic [26:0] addr,
                      input logic [7:0] data, input logic ack, input logic [7:0] dout,
                      input logic ew, er, ewe, ev, input logic [7:0] ecd,
                      input logic [26:0] ema, input logic [7:0] emd);
      vec_t v;
      v.rst = rst; v.mreq = mreq; v.rd = rd; v.wr = wr; v.cs = cs; v.rnw = rnw;
      v.addr = addr; v.data = data; v.ack = ack; v.dout = dout;
      v.e_wait = ew; v.e_req = er; v.e_we = ewe; v.e_valid = ev;
      v.e_cdata = ecd; v.e_maddr = ema; v.e_mdin = emd;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic setin(input logic mreq, rd, wr, cs, rnw, input logic [26:0] addr,
                        input logic [7:0] data, input logic ack, input logic [7:0] dout);
      cpu_mreq = mreq; cpu_rd = rd; cpu_wr = wr; map_ram_cs = cs; map_rnw = rnw;
      map_addr = addr; map_data = data; mem_ack = ack; mem_dout = dout;
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   rises;
      logic prev;

      reset = 1'b1;
      setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      cyc(); cyc();

      //   rst mreq rd wr cs rnw addr         data   ack dout   wait req we val cdata  maddr        mdin
      add(1, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 0, 0, 8'hFF, NA,          8'h00);
      // read, ack at N+3
      add(0, 1, 1, 0, 1, 0, AA,          8'h00, 0, 8'h00, 1, 0, 0, 0, 8'hFF, NA,          8'h00);
      add(0, 1, 1, 0, 1, 0, AA,          8'h00, 0, 8'h00, 1, 1, 0, 0, 8'hFF, AA,          8'h00);
      add(0, 1, 1, 0, 1, 0, AA,          8'h00, 0, 8'h00, 1, 1, 0, 0, 8'hFF, AA,          8'h00);
      add(0, 1, 1, 0, 1, 0, AA,          8'h00, 1, 8'hA5, 1, 1, 0, 0, 8'hFF, AA,          8'h00);
      add(0, 1, 1, 0, 1, 0, AA,          8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA5, AA,          8'h00);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA5, AA,          8'h00);
      // stray ack in IDLE is ignored
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 1, 8'h5A, 0, 0, 0, 1, 8'hA5, AA,          8'h00);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 0, 1, 8'hA5, AA,          8'h00);
      // write, ack at N+2
      add(0, 1, 0, 1, 1, 0, AB,          8'h3C, 0, 8'h00, 1, 0, 0, 1, 8'hA5, AA,          8'h00);
      add(0, 1, 0, 1, 1, 0, AB,          8'h3C, 0, 8'h00, 1, 1, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 1, 0, 1, 1, 0, AB,          8'h3C, 1, 8'hEE, 1, 1, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 1, 0, 1, 1, 0, AB,          8'h3C, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      // dropped write to a read-only target
      add(0, 1, 0, 1, 1, 1, 27'h0000100, 8'h77, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 1, 0, 1, 1, 1, 27'h0000100, 8'h77, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      // unmapped address
      add(0, 1, 1, 0, 1, 0, NA,          8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 1, 1, 0, 1, 0, NA,          8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      // ram_cs low
      add(0, 1, 1, 0, 0, 0, AA,          8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 1, 1, 0, 0, 0, AA,          8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, AB,          8'h3C);
      // rd+wr together: write wins; map changes during BUSY/HOLD ignored
      add(0, 1, 1, 1, 1, 0, 27'h0000010, 8'h81, 0, 8'h00, 1, 0, 1, 0, 8'hA5, AB,          8'h3C);
      add(0, 1, 1, 1, 1, 0, 27'h0000010, 8'h81, 0, 8'h00, 1, 1, 1, 0, 8'hA5, 27'h0000010, 8'h81);
      add(0, 1, 1, 1, 0, 0, 27'h5555555, 8'h11, 1, 8'h00, 1, 1, 1, 0, 8'hA5, 27'h0000010, 8'h81);
      add(0, 1, 1, 1, 1, 0, 27'h0001234, 8'h22, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 27'h0000010, 8'h81);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 1, 0, 8'hA5, 27'h0000010, 8'h81);
      // minimum latency read: ack at N+1
      add(0, 1, 1, 0, 1, 0, 27'h0000020, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'hA5, 27'h0000010, 8'h81);
      add(0, 1, 1, 0, 1, 0, 27'h0000020, 8'h00, 1, 8'h3C, 1, 1, 0, 0, 8'hA5, 27'h0000020, 8'h00);
      add(0, 1, 1, 0, 1, 0, 27'h0000020, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 27'h0000020, 8'h00);
      add(0, 0, 0, 0, 0, 0, 27'h0,       8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h3C, 27'h0000020, 8'h00);

      foreach (vq[i]) begin
         cyc();
         reset = vq[i].rst;
         setin(vq[i].mreq, vq[i].rd, vq[i].wr, vq[i].cs, vq[i].rnw,
               vq[i].addr, vq[i].data, vq[i].ack, vq[i].dout);
         @(negedge clk);
         chk($sformatf("v%0d cpu_wait", i),       32'(cpu_wait),       32'(vq[i].e_wait));
         chk($sformatf("v%0d mem_req", i),        32'(mem_req),        32'(vq[i].e_req));
         chk($sformatf("v%0d mem_we", i),         32'(mem_we),         32'(vq[i].e_we));
         chk($sformatf("v%0d cpu_data_valid", i), 32'(cpu_data_valid), 32'(vq[i].e_valid));
         chk($sformatf("v%0d cpu_data", i),       32'(cpu_data),       32'(vq[i].e_cdata));
         chk($sformatf("v%0d mem_addr", i),       32'(mem_addr),       32'(vq[i].e_maddr));
         chk($sformatf("v%0d mem_din", i),        32'(mem_din),        32'(vq[i].e_mdin));
         chk($sformatf("v%0d err", i),            32'(err),            32'd0);
      end

      // Single issue: CPU holds the read for 20+ cycles after the ack.
      rises = 0;
      cyc(); setin(1, 1, 0, 1, 0, 27'h0000040, 8'h00, 0, 8'h00);
      @(negedge clk); prev = mem_req;
      for (int c = 0; c < 25; c++) begin
         cyc(); mem_ack = (c == 1); mem_dout = (c == 1) ? 8'h5D : 8'h00;
         @(negedge clk);
         if (mem_req && !prev) rises++;
         prev = mem_req;
      end
      chk("single_issue_rises", 32'(rises), 32'd1);
      chk("single_issue_data", 32'(cpu_data), 32'h5D);
      chk("single_issue_wait", 32'(cpu_wait), 32'd0);
      cyc(); setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      @(negedge clk);
      // Second access after mreq low starts a fresh transaction.
      cyc(); setin(1, 1, 0, 1, 0, 27'h0000044, 8'h00, 0, 8'h00);
      @(negedge clk); prev = mem_req;
      for (int c = 0; c < 6; c++) begin
         cyc(); mem_ack = (c == 0); mem_dout = (c == 0) ? 8'h6B : 8'h00;
         @(negedge clk);
         if (mem_req && !prev) rises++;
         prev = mem_req;
      end
      chk("second_access_rises", 32'(rises), 32'd2);
      chk("second_access_data", 32'(cpu_data), 32'h6B);
      chk("second_access_addr", 32'(mem_addr), 32'h0000044);

      // Reset while BUSY: a write at N, reset during N+2, late ack at N+4.
      cyc(); setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      cyc();
      cyc(); setin(1, 0, 1, 1, 0, 27'h0000080, 8'h5A, 0, 8'h00);
      cyc();
      @(negedge clk);
      chk("rstbusy_req_before", 32'(mem_req), 32'd1);
      chk("rstbusy_we_before", 32'(mem_we), 32'd1);
      cyc(); reset = 1'b1; setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      cyc(); reset = 1'b0;
      @(negedge clk);
      chk("rstbusy_req", 32'(mem_req), 32'd0);
      chk("rstbusy_wait", 32'(cpu_wait), 32'd0);
      chk("rstbusy_cdata", 32'(cpu_data), 32'hFF);
      chk("rstbusy_valid", 32'(cpu_data_valid), 32'd0);
      chk("rstbusy_maddr", 32'(mem_addr), 32'(NA));
      chk("rstbusy_we", 32'(mem_we), 32'd0);
      chk("rstbusy_mdin", 32'(mem_din), 32'h00);
      cyc(); mem_ack = 1'b1; mem_dout = 8'h99;
      cyc(); mem_ack = 1'b0; mem_dout = 8'h00;
      @(negedge clk);
      chk("late_ack_req", 32'(mem_req), 32'd0);
      chk("late_ack_cdata", 32'(cpu_data), 32'hFF);
      chk("late_ack_valid", 32'(cpu_data_valid), 32'd0);
      chk("late_ack_err", 32'(err), 32'd0);

`ifdef MAPPER_MEM_TIMEOUT_EN
      // Ack on the timeout cycle wins: no error.
      cyc(); setin(1, 1, 0, 1, 0, 27'h0000090, 8'h00, 0, 8'h00);
      cyc(); cyc(); cyc();
      cyc(); mem_ack = 1'b1; mem_dout = 8'h42;
      @(negedge clk);
      chk("to_race_req_n4", 32'(mem_req), 32'd1);
      cyc(); mem_ack = 1'b0; mem_dout = 8'h00;
      @(negedge clk);
      chk("to_race_req", 32'(mem_req), 32'd0);
      chk("to_race_cdata", 32'(cpu_data), 32'h42);
      chk("to_race_err", 32'(err), 32'd0);
      cyc(); setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      cyc();
      // No ack: request aborts after 4 BUSY cycles.
      cyc(); setin(1, 1, 0, 1, 0, 27'h0000094, 8'h00, 0, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         @(negedge clk);
         chk($sformatf("to_req_n%0d", k), 32'(mem_req), 32'd1);
      end
      cyc();
      @(negedge clk);
      chk("to_req_drop", 32'(mem_req), 32'd0);
      chk("to_wait_drop", 32'(cpu_wait), 32'd0);
      chk("to_cdata", 32'(cpu_data), 32'hFF);
      chk("to_valid", 32'(cpu_data_valid), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      cyc(); setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      cyc(); setin(1, 1, 0, 1, 0, 27'h0000098, 8'h00, 0, 8'h00);
      cyc(); mem_ack = 1'b1; mem_dout = 8'h12;
      cyc(); mem_ack = 1'b0; mem_dout = 8'h00;
      @(negedge clk);
      chk("to_sticky_cdata", 32'(cpu_data), 32'h12);
      chk("to_sticky_err", 32'(err), 32'd1);
      cyc(); reset = 1'b1; setin(0, 0, 0, 0, 0, 27'h0, 8'h00, 0, 8'h00);
      cyc(); reset = 1'b0;
      @(negedge clk);
      chk("to_err_reset", 32'(err), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
